hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Parametrised hazard unit for the MIPS pipeline. Replaces the fixed E/M comparator stall logic with a shift-register scoreboard of in-flight register writes; each entry carries a Tnew countdown.
- Owns the multiply/divide busy countdown, so no external busy/start is needed.
- Stalls eret while an mtc0 to EPC is in flight, and keeps a saturating stall-cycle counter.
- Sits beside the D stage and drives the D/E stall/bubble control.

Parameters:
- RA_W, 5, register address width
- DEPTH, 3, tracked stages after D (E, M, W, ...)
- TNEW_W, 2, Tnew/Tuse field width
- MULT_CYCLES, 5, mult/multu busy cycles
- DIV_CYCLES, 10, div/divu busy cycles
- CNT_W, 32, stall counter width

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- valid_d  in  1  D holds a real instruction
- rs_d  in  RA_W  source rs
- rt_d  in  RA_W  source rt
- tuse_rs_d  in  TNEW_W  Tuse of rs; all-ones = unused
- tuse_rt_d  in  TNEW_W  Tuse of rt; all-ones = unused
- wa_d  in  RA_W  destination; 0 = no write
- tnew_d  in  TNEW_W  Tnew on entering E (ALU = 1, load = 2, link = 0)
- md_start_d  in  1  mult/multu/div/divu
- md_div_d  in  1  start is a divide
- md_use_d  in  1  mfhi/mflo/mthi/mtlo/mult/div class
- eret_d  in  1  instruction is eret
- epc_wr_d  in  1  instruction is mtc0 to EPC (rd = 14)
- flush  in  1  exception/eret flush of E..last stage
- stall  out  1  hold F/D, bubble into E
- md_busy  out  1  MDU countdown nonzero
- stall_cnt  out  CNT_W  total stall cycles, saturating

Behaviour:
- Reset, synchronous and active-high:
  - all entries cleared (wa = 0, tnew = 0, epc = 0)
  - md counter = 0
  - stall_cnt = 0
  - stall = 0 combinationally from the cleared state.
- Entry format: {wa, tnew, epc}. Entry[0] is E; entry[DEPTH-1] is the last tracked stage.
- Data hazard: combinational.
  - stall_rs = valid_d & rs_d != 0 & tuse_rs_d != all-ones & OR over i of (entry[i].wa == rs_d & entry[i].tnew > tuse_rs_d).
  - stall_rt is the same with rt.
- MDU hazard: stall_md = valid_d & md_use_d & (md_cnt != 0).
- CP0 hazard: stall_cp0 = valid_d & eret_d & OR over i of entry[i].epc.
- stall = stall_rs | stall_rt | stall_md | stall_cp0, forced to 0 while flush = 1.
- issue = valid_d & ~stall & ~flush.
- Each clock, entries shift:
  - entry[i+1] <= entry[i] with tnew decremented, saturating at 0.
  - entry[0] <= issue ? {wa_d, tnew_d, epc_wr_d} : bubble (all zero).
  - The oldest entry is dropped.
- flush clears every entry in the same clock edge that would shift, so all entries are 0 the next cycle. A D instruction present during flush is not recorded.
- md counter:
  - On issue & md_start_d, load DIV_CYCLES if md_div_d, else MULT_CYCLES.
  - Otherwise decrement while nonzero.
  - flush does not clear it: the operation is already committed.
  - A load is only possible when the counter is 0, because md_use covers starts.
- md_busy = (md_cnt != 0).
- stall_cnt increments on every cycle with stall = 1 and saturates at all-ones.
- Writes to register 0 never create hazards; wa = 0 entries are inert.
- Simultaneous reset and flush: reset wins.
- Reset mid-MDU: counter cleared immediately.

Decomposition:
- Shared package/header (alongside the existing head defines):
  - TNEW_UNUSED constant (all-ones)
  - scoreboard entry field widths
  - default MULT_CYCLES and DIV_CYCLES
- One natural sub-module, sb_entry_compare: per-entry match plus Tnew > Tuse comparator, instantiated DEPTH x 2 with a generate loop.
- The MDU countdown and stall counter stay inline.

Test Plan:
- Load-use: issue lw with wa=8, tnew=2; next cycle D has rs=8, tuse=1 -> stall=1 for 1 cycle, then 0; stall_cnt = 1.
- ALU-to-branch: issue addu with wa=9, tnew=1; next D has beq with rt=9, tuse=0 -> stall 1 cycle. Same with tuse=1 -> no stall.
- Register 0 and unused source: wa=0 load followed by rs=0 user, and a user with tuse=3 -> stall never asserted.
- MDU: issue div -> md_busy high for 10 cycles. An mflo issued right after stalls exactly 10 cycles; mult gives 5.
- eret after mtc0 EPC: mtc0 (epc_wr=1) then eret -> stall for DEPTH cycles until the entry exits. With flush asserted on cycle 1 -> stall drops next cycle.
- Saturation/reset: CNT_W=4 with 20 stalled cycles -> stall_cnt = 15. Synchronous reset during a div -> md_busy=0 and stall_cnt=0 the following cycle.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the hazard scoreboard: default geometry, the
// "source unused" Tuse encoding, and MDU latencies.
package hazard_scoreboard_pkg;

    // Default geometry of the scoreboard
    localparam int HS_RA_W   = 5;   // register address width
    localparam int HS_TNEW_W = 2;   // Tnew / Tuse field width
    localparam int HS_DEPTH  = 3;   // tracked stages after D (E, M, W)
    localparam int HS_CNT_W  = 32;  // stall cycle counter width

    // Entry field widths: {wa, tnew, epc}
    localparam int SB_WA_W   = HS_RA_W;
    localparam int SB_TNEW_W = HS_TNEW_W;
    localparam int SB_EPC_W  = 1;

    // Default multiply/divide unit busy latencies
    localparam int HS_MULT_CYCLES = 5;
    localparam int HS_DIV_CYCLES  = 10;

    // A Tuse of all-ones marks a source operand the instruction never reads
    localparam logic [HS_TNEW_W-1:0] TNEW_UNUSED = '1;

    // Width needed to hold the longer of the two MDU latencies
    function automatic int md_cnt_w(input int mult_cycles, input int div_cycles);
        int longest;
        longest = (div_cycles > mult_cycles) ? div_cycles : mult_cycles;
        return (longest < 1) ? 1 : $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_entry_compare.sv
// Per-entry hazard comparator: the entry writes the source register and its
// result will not be ready in time (Tnew > Tuse). Writes to r0 never match.
module sb_entry_compare
    import hazard_scoreboard_pkg::*;
#(
    parameter int RA_W   = HS_RA_W,
    parameter int TNEW_W = HS_TNEW_W
) (
    input  logic [RA_W-1:0]   i_wa,
    input  logic [TNEW_W-1:0] i_tnew,
    input  logic [RA_W-1:0]   i_src,
    input  logic [TNEW_W-1:0] i_tuse,
    output logic              o_hit
);

    logic w_addr_match;
    logic w_late;

    assign w_addr_match = (i_wa != '0) && (i_wa == i_src);
    assign w_late       = (i_tnew > i_tuse);
    assign o_hit        = w_addr_match & w_late;

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard beside the D stage. In-flight register writes shift
// through a DEPTH-entry scoreboard with a Tnew countdown; a D instruction
// stalls while any source it reads is produced too late, while the MDU is
// busy and it touches HI/LO, or while an mtc0 to EPC is ahead of an eret.
//
// Control contract: stall holds F/D and injects a bubble into E. A D
// instruction is accepted (issued) in a cycle where valid_d=1, stall=0 and
// flush=0; only issued instructions enter the scoreboard or start the MDU.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int RA_W        = HS_RA_W,
    parameter int DEPTH       = HS_DEPTH,
    parameter int TNEW_W      = HS_TNEW_W,
    parameter int MULT_CYCLES = HS_MULT_CYCLES,
    parameter int DIV_CYCLES  = HS_DIV_CYCLES,
    parameter int CNT_W       = HS_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_d,
    input  logic [RA_W-1:0]   rs_d,
    input  logic [RA_W-1:0]   rt_d,
    input  logic [TNEW_W-1:0] tuse_rs_d,
    input  logic [TNEW_W-1:0] tuse_rt_d,
    input  logic [RA_W-1:0]   wa_d,
    input  logic [TNEW_W-1:0] tnew_d,
    input  logic              md_start_d,
    input  logic              md_div_d,
    input  logic              md_use_d,
    input  logic              eret_d,
    input  logic              epc_wr_d,
    input  logic              flush,
    output logic              stall,
    output logic              md_busy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam int                MD_W       = md_cnt_w(MULT_CYCLES, DIV_CYCLES);
    localparam logic [MD_W-1:0]   MD_MULT    = MD_W'(MULT_CYCLES);
    localparam logic [MD_W-1:0]   MD_DIV     = MD_W'(DIV_CYCLES);
    localparam logic [MD_W-1:0]   MD_ONE     = MD_W'(1);
    localparam logic [TNEW_W-1:0] TNEW_ONE   = TNEW_W'(1);
    localparam logic [TNEW_W-1:0] TUSE_NONE  = {TNEW_W{1'b1}};
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);

    // Scoreboard entries: index 0 is E, index DEPTH-1 is the oldest tracked stage
    logic [DEPTH-1:0][RA_W-1:0]   r_wa;
    logic [DEPTH-1:0][TNEW_W-1:0] r_tnew;
    logic [DEPTH-1:0]             r_epc;

    logic [MD_W-1:0]  r_md_cnt;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [DEPTH-1:0] w_hit_rs;
    logic [DEPTH-1:0] w_hit_rt;
    logic             w_rs_live;
    logic             w_rt_live;
    logic             w_stall_rs;
    logic             w_stall_rt;
    logic             w_stall_md;
    logic             w_stall_cp0;
    logic             w_stall;
    logic             w_issue;
    logic             w_md_load;
    logic             w_cnt_sat;

    // One comparator pair (rs, rt) per tracked stage
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cmp
        sb_entry_compare #(
            .RA_W   (RA_W),
            .TNEW_W (TNEW_W)
        ) u_cmp_rs (
            .i_wa   (r_wa[gi]),
            .i_tnew (r_tnew[gi]),
            .i_src  (rs_d),
            .i_tuse (tuse_rs_d),
            .o_hit  (w_hit_rs[gi])
        );

        sb_entry_compare #(
            .RA_W   (RA_W),
            .TNEW_W (TNEW_W)
        ) u_cmp_rt (
            .i_wa   (r_wa[gi]),
            .i_tnew (r_tnew[gi]),
            .i_src  (rt_d),
            .i_tuse (tuse_rt_d),
            .o_hit  (w_hit_rt[gi])
        );
    end

    // A source takes part only when it is a real register that is actually read
    assign w_rs_live   = valid_d && (rs_d != '0) && (tuse_rs_d != TUSE_NONE);
    assign w_rt_live   = valid_d && (rt_d != '0) && (tuse_rt_d != TUSE_NONE);

    assign w_stall_rs  = w_rs_live & (|w_hit_rs);
    assign w_stall_rt  = w_rt_live & (|w_hit_rt);
    assign w_stall_md  = valid_d & md_use_d & (r_md_cnt != '0);
    assign w_stall_cp0 = valid_d & eret_d & (|r_epc);

    // A flush discards D anyway, so holding it would only lose a cycle
    assign w_stall     = (w_stall_rs | w_stall_rt | w_stall_md | w_stall_cp0) & ~flush;
    assign w_issue     = valid_d & ~w_stall & ~flush;
    assign w_md_load   = w_issue & md_start_d;
    assign w_cnt_sat   = (r_stall_cnt == '1);

    // Shift the scoreboard one stage per clock, aging Tnew; flush empties it
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wa   <= '0;
            r_tnew <= '0;
            r_epc  <= '0;
        end else begin
            r_wa[0]   <= w_issue ? wa_d     : '0;
            r_tnew[0] <= w_issue ? tnew_d   : '0;
            r_epc[0]  <= w_issue ? epc_wr_d : 1'b0;
            for (int i = 1; i < DEPTH; i++) begin
                r_wa[i]   <= r_wa[i-1];
                r_tnew[i] <= (r_tnew[i-1] != '0) ? (r_tnew[i-1] - TNEW_ONE) : '0;
                r_epc[i]  <= r_epc[i-1];
            end
        end
    end

    // MDU busy countdown; the operation is committed, so flush leaves it running
    always_ff @(posedge clk) begin
        if (reset) begin
            r_md_cnt <= '0;
        end else if (w_md_load) begin
            r_md_cnt <= md_div_d ? MD_DIV : MD_MULT;
        end else if (r_md_cnt != '0) begin
            r_md_cnt <= r_md_cnt - MD_ONE;
        end
    end

    // Saturating count of cycles spent stalled
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !w_cnt_sat) begin
            r_stall_cnt <= r_stall_cnt + CNT_ONE;
        end
    end

    assign stall     = w_stall;
    assign md_busy   = (r_md_cnt != '0);
    assign stall_cnt = r_stall_cnt;

endmodule
